ex_mdu: RTL

//  Iterative RV32M multiply/divide unit beside the EX-stage ALU. Accepts one MUL/DIV-class op,

---
 rtl/ex_mdu_pkg.sv | 41 ++++
 rtl/ex_mdu_div_step.sv | 23 ++
 rtl/ex_mdu.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// Op codes follow RV32M funct3; states cover the iterate/report FSM.
package ex_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic int mdu_cnt_w(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic logic rs1_signed(
    input logic [2:0] op
  );
    return (op == MDU_MUL) || (op == MDU_MULH) ||
           (op == MDU_MULHSU) || (op == MDU_DIV) ||
           (op == MDU_REM);
  endfunction

  function automatic logic rs2_signed(
    input logic [2:0] op
  );
    return (op == MDU_MUL) || (op == MDU_MULH) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/ex_mdu_div_step.sv
// One restoring-divide step on unsigned magnitudes.
// Ports: rem_i/dvd_bit_i/div_i in; rem_o, quotient bit q_o out.
module ex_mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_bit_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  // rem_i < div_i always holds, so sh < 2*div_i and the
  // top bit of diff is a clean borrow flag.
  assign sh    = {rem_i, dvd_bit_i};
  assign diff  = sh - {1'b0, div_i};
  assign q_o   = ~diff[XLEN];
  assign rem_o = q_o ? diff[XLEN-1:0] : sh[XLEN-1:0];

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit beside the EX ALU.
// In: clk, rst (sync, high), start_i, op_i, rs1_i, rs2_i,
//   wd_i, flush_i. Out: stall_req_o, valid_o, result_o, wd_o.
// EX_MDU_FAST_MUL_EN: single-cycle multiplier for MUL*.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      wd_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      wd_o
);

  localparam int CW = mdu_cnt_w(XLEN);
  localparam int DN = XLEN / DIV_UNROLL;
  localparam logic [CW-1:0] MUL_CNT = CW'(XLEN - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN-1:0] res_q, out_q;
  logic [4:0]      wd_q, wdo_q;
  logic [2:0]      op_q;
  logic            neg_q, rneg_q;
  logic [CW-1:0]   cnt_q;

  logic            load, step, res_en;
  logic [XLEN-1:0] res_d;

  // Product/quotient sign fix-up applied once at the end.
  function automatic logic [XLEN-1:0] fixup(
    input logic [2:0]      op,
    input logic            neg,
    input logic            rneg,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo
  );
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   r;
    p = {hi, lo};
    if (neg) p = -p;
    r = '0;
    unique case (1'b1)
      op == MDU_MUL:           r = p[XLEN-1:0];
      ~op[2] & (|op[1:0]):     r = p[2*XLEN-1:XLEN];
      op[2] & ~op[1]:          r = neg ? -lo : lo;
      op[2] & op[1]:           r = rneg ? -hi : hi;
      default:                 r = '0;
    endcase
    return r;
  endfunction

  // Operand decode on the inputs, used at launch.
  logic            n1, n2, dz, ovf;
  logic [XLEN-1:0] m1, m2, spec_res;

  assign n1 = rs1_signed(op_i) & rs1_i[XLEN-1];
  assign n2 = rs2_signed(op_i) & rs2_i[XLEN-1];
  assign m1 = n1 ? -rs1_i : rs1_i;
  assign m2 = n2 ? -rs2_i : rs2_i;
  assign dz = op_i[2] & (rs2_i == '0);
  assign ovf = (op_i == MDU_DIV || op_i == MDU_REM) &&
               (rs1_i == SMIN) && (rs2_i == '1);

  // op_i[1] separates REM* from DIV*.
  always_comb begin
    spec_res = '1;
    if (ovf)
      spec_res = op_i[1] ? '0 : SMIN;
    else if (op_i[1])
      spec_res = rs1_i;
  end

`ifdef EX_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fp;
  logic [XLEN-1:0]   fast_res;

  assign fp = {{XLEN{1'b0}}, m1} * {{XLEN{1'b0}}, m2};
  assign fast_res = fixup(op_i, n1 ^ n2, n1,
                          fp[2*XLEN-1:XLEN],
                          fp[XLEN-1:0]);
`endif

  // Shift-add multiply: {hi,lo} holds partial product and
  // the not-yet-consumed multiplier bits.
  logic [XLEN:0]   msum;
  logic [XLEN-1:0] mhi, mlo;

  assign msum = {1'b0, hi_q} +
                (lo_q[0] ? {1'b0, b_q} : '0);
  assign mhi  = msum[XLEN:1];
  assign mlo  = {msum[0], lo_q[XLEN-1:1]};

  // Divide: hi is the partial remainder, lo shifts the
  // dividend out at the top and quotient bits in at the
  // bottom.
  logic [XLEN-1:0]       r_c [DIV_UNROLL+1];
  logic [XLEN-1:0]       d_c [DIV_UNROLL+1];
  logic [DIV_UNROLL-1:0] qb;

  assign r_c[0] = hi_q;
  assign d_c[0] = lo_q;

  for (genvar k = 0; k < DIV_UNROLL; k++) begin : g_div
    ex_mdu_div_step #(
      .XLEN(XLEN)
    ) u_step (
      .rem_i    (r_c[k]),
      .dvd_bit_i(d_c[k][XLEN-1]),
      .div_i    (b_q),
      .rem_o    (r_c[k+1]),
      .q_o      (qb[k])
    );
    assign d_c[k+1] = {d_c[k][XLEN-2:0], qb[k]};
  end

  logic [XLEN-1:0] step_hi, step_lo;

  assign step_hi = op_q[2] ? r_c[DIV_UNROLL] : mhi;
  assign step_lo = op_q[2] ? d_c[DIV_UNROLL] : mlo;

  always_comb begin
    state_d     = state_q;
    stall_req_o = 1'b0;
    valid_o     = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    res_en      = 1'b0;
    res_d       = '0;
    unique case (1'b1)
      state_q == MDU_IDLE: begin
        stall_req_o = start_i & ~flush_i;
        if (start_i && !flush_i) begin
          load = 1'b1;
          if (dz || ovf) begin
            state_d = MDU_DONE;
            res_en  = 1'b1;
            res_d   = spec_res;
          end
`ifdef EX_MDU_FAST_MUL_EN
          else if (!op_i[2]) begin
            state_d = MDU_DONE;
            res_en  = 1'b1;
            res_d   = fast_res;
          end
`endif
          else begin
            state_d = MDU_CALC;
          end
        end
      end
      state_q == MDU_CALC: begin
        stall_req_o = 1'b1;
        if (flush_i) begin
          state_d = MDU_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            state_d = MDU_DONE;
            res_en  = 1'b1;
            res_d   = fixup(op_q, neg_q, rneg_q,
                            step_hi, step_lo);
          end
        end
      end
      state_q == MDU_DONE: begin
        valid_o = ~flush_i;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      wd_q    <= '0;
      wdo_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q   <= op_i;
        wd_q   <= wd_i;
        neg_q  <= n1 ^ n2;
        rneg_q <= n1;
        hi_q   <= '0;
        lo_q   <= op_i[2] ? m1 : m2;
        b_q    <= op_i[2] ? m2 : m1;
        cnt_q  <= op_i[2] ? DIV_CNT : MUL_CNT;
      end else if (step) begin
        hi_q  <= step_hi;
        lo_q  <= step_lo;
        cnt_q <= cnt_q - CW'(1);
      end
      if (res_en)
        res_q <= res_d;
      if (valid_o) begin
        out_q <= res_q;
        wdo_q <= wd_q;
      end
    end
  end

  // A flushed DONE must not disturb what the pipeline last saw.
  assign result_o = valid_o ? res_q : out_q;
  assign wd_o     = valid_o ? wd_q  : wdo_q;

endmodule
